// File: rtl/prim_arbiter_wrr_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package prim_arbiter_wrr_pkg;

  typedef enum logic {
    WrrIdle,
    WrrLock
  } wrr_state_e;

  // A zero weight still grants one burst per turn.
  function automatic logic [15:0] wrr_weight_eff(
    input logic [15:0] w
  );
    return (w == '0) ? 16'd1 : w;
  endfunction

endpackage

// File: rtl/prim_arbiter_wrr_pick.sv
// Rotating-priority picker: first request at or after ptr_i, wrapping at N.
module prim_arbiter_wrr_pick #(
  parameter int N = 4,
  localparam int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0] dreq;
  logic [2*N-2:0] ppc;
  logic [2*N-1:0] doh;

  // Upper copy of req covers the wrapped part of the scan.
  always_comb begin
    dreq = {req_i, req_i} & ({(2*N){1'b1}} << ptr_i);
    ppc[0] = dreq[0];
    for (int k = 1; k < 2*N-1; k++) begin
      ppc[k] = ppc[k-1] | dreq[k];
    end
    doh[0] = dreq[0];
    for (int k = 1; k < 2*N; k++) begin
      doh[k] = dreq[k] & ~ppc[k-1];
    end
    onehot_o = doh[N-1:0] | doh[2*N-1:N];
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_o[i]) idx_o = IdxW'(i);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/prim_arbiter_wrr_lock.sv
// N:1 weighted round-robin arbiter that holds the grant for a whole burst.
module prim_arbiter_wrr_lock
  import prim_arbiter_wrr_pkg::*;
#(
  parameter int N = 4,
  parameter int DW = 32,
  parameter int WeightW = 4,
  parameter bit EnDataPort = 1'b1,
  localparam int IdxW = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         last_i,
  input  logic [N-1:0][DW-1:0] data_i,
  input  logic [N*WeightW-1:0] weight_i,
  output logic [N-1:0]         gnt_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 valid_o,
  output logic [DW-1:0]        data_o,
  input  logic                 ready_i,
  output logic                 locked_o
);

  wrr_state_e state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [WeightW-1:0] cnt_q, cnt_d;

  logic [N-1:0] pick_oh;
  logic [IdxW-1:0] pick_idx;
  logic pick_any;

  logic [IdxW-1:0] idx;
  logic valid, accept, done;
  logic [WeightW:0] inc;
  logic [WeightW-1:0] c, w;

  prim_arbiter_wrr_pick #(
    .N(N)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .onehot_o(pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_o   = '0;
    idx     = pick_idx;
    valid   = pick_any;
    if (state_q == WrrLock) begin
      idx   = owner_q;
      valid = req_i[owner_q];
    end
    accept = valid & ready_i;
    done   = accept & last_i[idx];
    if (accept) begin
      gnt_o = (state_q == WrrLock) ? (N'(1) << owner_q) : pick_oh;
    end

    unique case (state_q)
      WrrIdle: begin
        if (valid && !done) begin
          state_d = WrrLock;
          owner_d = idx;
        end
      end
      WrrLock: begin
        if (done) state_d = WrrIdle;
      end
      default: state_d = WrrIdle;
    endcase

    // Credit: consecutive bursts by the pointer holder accumulate.
    inc = {1'b0, cnt_q} + (WeightW+1)'(1);
    if (idx == ptr_q) begin
      c = inc[WeightW] ? '1 : inc[WeightW-1:0];
    end else begin
      c = WeightW'(1);
    end
    w = WeightW'(wrr_weight_eff(16'(weight_i[idx*WeightW +: WeightW])));
    if (done) begin
      if (c >= w) begin
        ptr_d = (idx == IdxW'(N-1)) ? '0 : idx + IdxW'(1);
        cnt_d = '0;
      end else begin
        ptr_d = idx;
        cnt_d = c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WrrIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign idx_o    = idx;
  assign valid_o  = valid;
  assign locked_o = (state_q == WrrLock);

  if (EnDataPort) begin : g_data
    assign data_o = data_i[idx];
  end else begin : g_nodata
    assign data_o = '1;
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_gnt_hs: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (|gnt_o) |-> (ready_i && valid_o));
  a_lock_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (locked_o && !done) |=> $stable(idx_o));
  a_req_src: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_o && ready_i) |-> req_i[idx_o]);
  // Owner must keep requesting until its last beat is taken.
  a_owner_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    locked_o |-> req_i[owner_q]);
`endif

endmodule

// File: tb/tb_prim_arbiter_wrr_lock.sv
// Bench for prim_arbiter_wrr_lock: N=4 and N=3 instances vs a turn model.
module tb_prim_arbiter_wrr_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0] req_a, last_a, gnt_a;
  logic [3:0][31:0] din_a;
  logic [15:0] w_a;
  logic [1:0] idx_a;
  logic valid_a, locked_a, ready_a;
  logic [31:0] dout_a;

  logic [2:0] req_b, last_b, gnt_b;
  logic [2:0][31:0] din_b;
  logic [11:0] w_b;
  logic [1:0] idx_b;
  logic valid_b, locked_b, ready_b;
  logic [31:0] dout_b;

  prim_arbiter_wrr_lock #(.N(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_i(req_a), .last_i(last_a),
    .data_i(din_a), .weight_i(w_a),
    .gnt_o(gnt_a), .idx_o(idx_a),
    .valid_o(valid_a), .data_o(dout_a),
    .ready_i(ready_a), .locked_o(locked_a)
  );

  prim_arbiter_wrr_lock #(.N(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_i(req_b), .last_i(last_b),
    .data_i(din_b), .weight_i(w_b),
    .gnt_o(gnt_b), .idx_o(idx_b),
    .valid_o(valid_b), .data_o(dout_b),
    .ready_i(ready_b), .locked_o(locked_b)
  );

  int errs = 0;
  int checks = 0;
  bit started = 0;

  // Turn model: who holds the turn, bursts used, and a held winner.
  int m_ptr[2];
  int m_cnt[2];
  int m_owner[2];
  bit m_lock[2];

  int t1[5] = '{0, 1, 2, 3, 0};
  int t2[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int n_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [3:0] req_of(int d);
    return (d == 0) ? req_a : {1'b0, req_b};
  endfunction

  function automatic logic [3:0] last_of(int d);
    return (d == 0) ? last_a : {1'b0, last_b};
  endfunction

  function automatic logic rdy_of(int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction

  function automatic int weight_of(int d, int i);
    return (d == 0) ? int'(w_a[i*4 +: 4]) : int'(w_b[i*4 +: 4]);
  endfunction

  function automatic logic [31:0] data_of(int d, int i);
    return (d == 0) ? din_a[i] : din_b[i];
  endfunction

  function automatic void pick(int d, output bit v, output int ix);
    logic [3:0] r;
    bit found;
    int j;
    r = req_of(d);
    ix = 0;
    found = 0;
    if (m_lock[d]) begin
      ix = m_owner[d];
      v = r[ix];
    end else begin
      v = |r;
      for (int k = 0; k < n_of(d); k++) begin
        j = (m_ptr[d] + k) % n_of(d);
        if (!found && r[j]) begin
          ix = j;
          found = 1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    bit v;
    int ix, used, w;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ptr[d] = 0; m_cnt[d] = 0;
        m_owner[d] = 0; m_lock[d] = 0;
      end else begin
        pick(d, v, ix);
        if (v && rdy_of(d) && last_of(d)[ix]) begin
          used = (ix == m_ptr[d]) ? m_cnt[d] + 1 : 1;
          if (used > 15) used = 15;
          w = weight_of(d, ix);
          if (w == 0) w = 1;
          if (used >= w) begin
            m_ptr[d] = (ix + 1) % n_of(d);
            m_cnt[d] = 0;
          end else begin
            m_ptr[d] = ix;
            m_cnt[d] = used;
          end
          m_lock[d] = 0;
        end else if (v) begin
          m_lock[d] = 1;
          m_owner[d] = ix;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit v;
    int ix;
    logic [3:0] eg;
    if (started && !rst) begin
      for (int d = 0; d < 2; d++) begin
        pick(d, v, ix);
        eg = (v && rdy_of(d)) ? (4'b0001 << ix) : 4'b0000;
        if (d == 0) begin
          lit("cmp_valid_a", 32'(valid_a), 32'(v));
          lit("cmp_gnt_a", 32'(gnt_a), 32'(eg));
          lit("cmp_idx_a", 32'(idx_a), 32'(ix));
          lit("cmp_lock_a", 32'(locked_a), 32'(m_lock[0]));
          lit("cmp_data_a", dout_a, data_of(0, ix));
        end else begin
          lit("cmp_valid_b", 32'(valid_b), 32'(v));
          lit("cmp_gnt_b", 32'({1'b0, gnt_b}), 32'(eg));
          lit("cmp_idx_b", 32'(idx_b), 32'(ix));
          lit("cmp_lock_b", 32'(locked_b), 32'(m_lock[1]));
          lit("cmp_data_b", dout_b, data_of(1, ix));
        end
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = '0; req_b = '0;
    last_a = '1; last_b = '1;
    ready_a = 1'b1; ready_b = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_a = '0; last_a = '1; din_a = '0;
    req_b = '0; last_b = '1; din_b = '0;
    w_a = 16'h1111; w_b = 12'h111;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1;

    at_neg();
    lit("rst_gnt", 32'(gnt_a), 32'd0);
    lit("rst_valid", 32'(valid_a), 32'd0);
    lit("rst_idx", 32'(idx_a), 32'd0);
    lit("rst_lock", 32'(locked_a), 32'd0);
    lit("rst_data", dout_a, 32'd0);
    lit("rst_ptr", 32'(u_a.ptr_q), 32'd0);
    lit("rst_valid_b", 32'(valid_b), 32'd0);
    step();

    for (int i = 0; i < 4; i++) din_a[i] = 32'hA000_0000 | 32'(i);
    for (int i = 0; i < 3; i++) din_b[i] = 32'hB000_0000 | 32'(i);

    // Equal weights: plain round robin.
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      lit("t1_idx", 32'(idx_a), 32'(t1[k]));
      lit("t1_gnt", 32'(gnt_a), 32'(4'b0001 << t1[k]));
      if (k == 1) lit("t1_data", dout_a, 32'hA000_0001);
      step();
    end

    // Requester 0 gets three bursts per turn.
    do_reset();
    w_a = 16'h1113;
    req_a = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      at_neg();
      lit("t2_idx", 32'(idx_a), 32'(t2[k]));
      step();
    end

    // Four-beat burst from requester 0 blocks requester 1.
    do_reset();
    w_a = 16'h1111;
    req_a = 4'b0011;
    last_a = 4'b0010;
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) last_a = 4'b0011;
      at_neg();
      lit("t3_gnt", 32'(gnt_a), 32'h1);
      if (b == 2 || b == 3) lit("t3_lock", 32'(locked_a), 32'h1);
      step();
    end
    at_neg();
    lit("t3_next", 32'(gnt_a), 32'h2);
    step();

    // Sink stalls: decision for requester 1 is held.
    do_reset();
    req_a = 4'b0110;
    ready_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req_a = 4'b0111;
      at_neg();
      lit("t4_idx", 32'(idx_a), 32'h1);
      lit("t4_gnt", 32'(gnt_a), 32'h0);
      if (c > 0) lit("t4_lock", 32'(locked_a), 32'h1);
      step();
    end
    ready_a = 1'b1;
    at_neg();
    lit("t4_gnt_rdy", 32'(gnt_a), 32'h2);
    step();
    at_neg();
    lit("t4_after", 32'(idx_a), 32'h2);
    step();

    // N=3 with zero weights: pointer wraps past the last requester.
    do_reset();
    w_b = 12'h000;
    req_b = 3'b010;
    at_neg();
    lit("t5_idx1", 32'(idx_b), 32'h1);
    step();
    req_b = 3'b100;
    at_neg();
    lit("t5_ptr2", 32'(u_b.ptr_q), 32'h2);
    lit("t5_idx2", 32'(idx_b), 32'h2);
    lit("t5_gnt2", 32'({1'b0, gnt_b}), 32'h4);
    step();
    req_b = 3'b011;
    at_neg();
    lit("t5_wrap", 32'(u_b.ptr_q), 32'h0);
    lit("t5_idx0", 32'(idx_b), 32'h0);
    step();
    req_b = '0;

    // Reset lands on beat 2 of a burst from requester 2.
    do_reset();
    req_a = 4'b0100;
    last_a = 4'b0000;
    at_neg();
    lit("t6_beat1", 32'(gnt_a), 32'h4);
    lit("t6_lock1", 32'(locked_a), 32'h0);
    step();
    rst = 1'b1;
    at_neg();
    lit("t6_lock2", 32'(locked_a), 32'h1);
    step();
    rst = 1'b0;
    req_a = 4'b0110;
    last_a = 4'b1111;
    at_neg();
    lit("t6_unlock", 32'(locked_a), 32'h0);
    lit("t6_ptr", 32'(u_a.ptr_q), 32'h0);
    lit("t6_idx", 32'(idx_a), 32'h1);
    lit("t6_gnt", 32'(gnt_a), 32'h2);
    step();
    req_a = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
